mac_decoder_pipe: RTL and testbench

MAC_DECODER_PIPE -- requirements
Module: mac_decoder_pipe

---
 rtl/mac_decoder_pipe_if.sv | 41 ++++
 rtl/mac_decoder_pipe.sv | 128 ++++++++++++
 tb/tb_mac_decoder_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_decoder_pipe_if.sv
// Datatype encoding and the beat-level bus of the MAC operand decoder.
// "slave" is the decoder side; "master" is the side that drives the input beat.
package mac_decoder_pipe_pkg;
    typedef logic [1:0] mac_datatype;
    localparam mac_datatype MAC_DATATYPE_INT9 = 2'd0;
    localparam mac_datatype MAC_DATATYPE_FP8  = 2'd1;
endpackage

interface mac_decoder_pipe_if #(
    parameter int LANES = 4,
    parameter int DW    = 9
);
    import mac_decoder_pipe_pkg::*;
    localparam int ZW = $clog2(LANES + 1);

    logic                  i_valid;
    logic                  o_ready;
    mac_datatype           i_datatype;
    logic [LANES*DW-1:0]   i_data;
    logic                  o_valid;
    logic                  i_ready;
    mac_datatype           o_datatype;
    logic [LANES-1:0]      o_iszero;
    logic [LANES-1:0]      o_sign;
    logic [LANES-1:0]      o_isnan;
    logic [LANES*4-1:0]    o_exp;
    logic [LANES*9-1:0]    o_mant;
    logic [ZW-1:0]         o_zero_cnt;

    modport slave (
        input  i_valid, i_datatype, i_data, i_ready,
        output o_ready, o_valid, o_datatype, o_iszero, o_sign, o_isnan,
               o_exp, o_mant, o_zero_cnt
    );

    modport master (
        output i_valid, i_datatype, i_data, i_ready,
        input  o_ready, o_valid, o_datatype, o_iszero, o_sign, o_isnan,
               o_exp, o_mant, o_zero_cnt
    );
endinterface

// File: rtl/mac_decoder_pipe.sv
// Two-stage valid/ready pipeline that decodes FP8 E4M3 or INT9 operand lanes.
// S1 holds the raw beat; S2 holds the decoded beat that drives the outputs.
module mac_decoder_pipe
    import mac_decoder_pipe_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    mac_decoder_pipe_if.slave    bus
);
    localparam int ZW = $clog2(LANES + 1);

    logic                  r_s1_valid;
    mac_datatype           r_s1_dtype;
    logic [LANES*DW-1:0]   r_s1_data;

    logic                  r_s2_valid;
    mac_datatype           r_s2_dtype;
    logic [LANES-1:0]      r_s2_iszero;
    logic [LANES-1:0]      r_s2_sign;
    logic [LANES-1:0]      r_s2_isnan;
    logic [LANES*4-1:0]    r_s2_exp;
    logic [LANES*9-1:0]    r_s2_mant;

    logic                  w_accept;
    logic                  w_s1_adv;
    logic                  w_is_fp8;
    logic [LANES-1:0]      w_iszero;
    logic [LANES-1:0]      w_sign;
    logic [LANES-1:0]      w_isnan;
    logic [LANES*4-1:0]    w_exp;
    logic [LANES*9-1:0]    w_mant;
    logic [ZW-1:0]         w_zero_cnt;

    // Ready depends only on stage occupancy and downstream ready, never on i_valid.
    assign bus.o_ready = !r_s1_valid || !r_s2_valid || bus.i_ready;
    assign w_accept    = bus.i_valid && bus.o_ready;
    assign w_s1_adv    = r_s1_valid && (!r_s2_valid || bus.i_ready);
    assign w_is_fp8    = (r_s1_dtype == MAC_DATATYPE_FP8);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_dtype <= '0;
            r_s1_data  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_dtype <= bus.i_datatype;
            r_s1_data  <= bus.i_data;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0] w_d;
            assign w_d = r_s1_data[gi*DW +: DW];

            always_comb begin
                w_iszero[gi]       = 1'b0;
                w_sign[gi]         = 1'b0;
                w_isnan[gi]        = 1'b0;
                w_exp[gi*4 +: 4]   = 4'd0;
                w_mant[gi*9 +: 9]  = 9'd0;
                if (w_is_fp8) begin
                    // d[8] is not part of the E4M3 encoding and is ignored.
                    w_sign[gi] = w_d[7];
                    if (w_d[6:0] == 7'd0) begin
                        w_iszero[gi] = 1'b1;
                    end else if (w_d[6:3] == 4'd0) begin
                        w_exp[gi*4 +: 4]  = 4'd1;
                        w_mant[gi*9 +: 9] = {6'b0, w_d[2:0]};
                    end else begin
                        w_exp[gi*4 +: 4]  = w_d[6:3];
                        w_mant[gi*9 +: 9] = {5'b0, 1'b1, w_d[2:0]};
                        w_isnan[gi]       = (w_d[6:3] == 4'hF) && (w_d[2:0] == 3'h7);
                    end
                end else begin
                    w_sign[gi]        = w_d[8];
                    w_mant[gi*9 +: 9] = w_d[8:0];
                    w_iszero[gi]      = (w_d == '0);
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_s2_valid  <= 1'b0;
            r_s2_dtype  <= '0;
            r_s2_iszero <= '0;
            r_s2_sign   <= '0;
            r_s2_isnan  <= '0;
            r_s2_exp    <= '0;
            r_s2_mant   <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid  <= 1'b1;
            r_s2_dtype  <= r_s1_dtype;
            r_s2_iszero <= w_iszero;
            r_s2_sign   <= w_sign;
            r_s2_isnan  <= w_isnan;
            r_s2_exp    <= w_exp;
            r_s2_mant   <= w_mant;
        end else if (r_s2_valid && bus.i_ready) begin
            r_s2_valid  <= 1'b0;
        end
    end

    always_comb begin
        w_zero_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_zero_cnt = w_zero_cnt + ZW'(r_s2_iszero[i]);
        end
    end

    assign bus.o_valid    = r_s2_valid;
    assign bus.o_datatype = r_s2_dtype;
    assign bus.o_iszero   = r_s2_iszero;
    assign bus.o_sign     = r_s2_sign;
    assign bus.o_isnan    = r_s2_isnan;
    assign bus.o_exp      = r_s2_exp;
    assign bus.o_mant     = r_s2_mant;
    assign bus.o_zero_cnt = w_zero_cnt;
endmodule

// File: tb/tb_mac_decoder_pipe.sv
// Directed bench for mac_decoder_pipe: decode vector table, stall stream, async reset.
module tb_mac_decoder_pipe;
    import mac_decoder_pipe_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    mac_decoder_pipe_if #(.LANES(4), .DW(9)) bus ();

    mac_decoder_pipe #(.LANES(4), .DW(9)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [1:0]  dt;
        logic [35:0] d;
        logic [15:0] exp;
        logic [35:0] mant;
        logic [3:0]  iszero;
        logic [3:0]  sign;
        logic [3:0]  isnan;
        logic [2:0]  zc;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] beat_data(input int k);
        logic [35:0] d;
        for (int n = 0; n < 4; n++) d[n*9 +: 9] = 9'(k*16 + n + 1);
        return d;
    endfunction

    // Called at a negedge with the pipeline empty or draining; returns at a negedge.
    task automatic run_vec(input int i);
        bus.i_valid    = 1'b1;
        bus.i_ready    = 1'b1;
        bus.i_datatype = vecs[i].dt;
        bus.i_data     = vecs[i].d;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk($sformatf("v%0d_lat1_valid", i), 64'(bus.o_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_valid", i),  64'(bus.o_valid),    64'd1);
        chk($sformatf("v%0d_dtype", i),  64'(bus.o_datatype), 64'(vecs[i].dt));
        chk($sformatf("v%0d_exp", i),    64'(bus.o_exp),      64'(vecs[i].exp));
        chk($sformatf("v%0d_mant", i),   64'(bus.o_mant),     64'(vecs[i].mant));
        chk($sformatf("v%0d_iszero", i), 64'(bus.o_iszero),   64'(vecs[i].iszero));
        chk($sformatf("v%0d_sign", i),   64'(bus.o_sign),     64'(vecs[i].sign));
        chk($sformatf("v%0d_isnan", i),  64'(bus.o_isnan),    64'(vecs[i].isnan));
        chk($sformatf("v%0d_zcnt", i),   64'(bus.o_zero_cnt), 64'(vecs[i].zc));
        $display("vec %0d dt=%0d data=%h -> exp=%h mant=%h z=%b s=%b n=%b zc=%0d",
                 i, vecs[i].dt, vecs[i].d, bus.o_exp, bus.o_mant,
                 bus.o_iszero, bus.o_sign, bus.o_isnan, bus.o_zero_cnt);
    endtask

    initial begin
        int          sent;
        int          rx;
        bit          saw_block;
        bit          prev_stall;
        logic [35:0] prev_mant;

        checks   = 0;
        failures = 0;

        vecs[0] = '{dt:2'd1, d:{9'h07F, 9'h080, 9'h003, 9'h038}, exp:16'hF017,
                    mant:{9'h00F, 9'h000, 9'h003, 9'h008},
                    iszero:4'b0100, sign:4'b0100, isnan:4'b1000, zc:3'd1};
        vecs[1] = '{dt:2'd0, d:{9'h100, 9'h0A5, 9'h000, 9'h1FF}, exp:16'h0000,
                    mant:{9'h100, 9'h0A5, 9'h000, 9'h1FF},
                    iszero:4'b0010, sign:4'b1001, isnan:4'b0000, zc:3'd1};
        vecs[2] = '{dt:2'd1, d:{4{9'h0C1}}, exp:16'h8888, mant:{4{9'h009}},
                    iszero:4'b0000, sign:4'b1111, isnan:4'b0000, zc:3'd0};
        vecs[3] = '{dt:2'd0, d:{4{9'h0C1}}, exp:16'h0000, mant:{4{9'h0C1}},
                    iszero:4'b0000, sign:4'b0000, isnan:4'b0000, zc:3'd0};
        vecs[4] = '{dt:2'd1, d:{9'h078, 9'h1FF, 9'h180, 9'h100}, exp:16'hFF00,
                    mant:{9'h008, 9'h00F, 9'h000, 9'h000},
                    iszero:4'b0011, sign:4'b0110, isnan:4'b0100, zc:3'd2};
        vecs[5] = '{dt:2'd0, d:36'd0, exp:16'h0000, mant:36'd0,
                    iszero:4'b1111, sign:4'b0000, isnan:4'b0000, zc:3'd4};
        vecs[6] = '{dt:2'd1, d:36'd0, exp:16'h0000, mant:36'd0,
                    iszero:4'b1111, sign:4'b0000, isnan:4'b0000, zc:3'd4};
        vecs[7] = '{dt:2'd2, d:{4{9'h0C1}}, exp:16'h0000, mant:{4{9'h0C1}},
                    iszero:4'b0000, sign:4'b0000, isnan:4'b0000, zc:3'd0};
        vecs[8] = '{dt:2'd1, d:{9'h008, 9'h087, 9'h007, 9'h001}, exp:16'h1111,
                    mant:{9'h008, 9'h007, 9'h007, 9'h001},
                    iszero:4'b0000, sign:4'b0100, isnan:4'b0000, zc:3'd0};

        rstn           = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_ready    = 1'b0;
        bus.i_datatype = MAC_DATATYPE_INT9;
        bus.i_data     = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_mant",  64'(bus.o_mant),  64'd0);
        chk("rst_exp",   64'(bus.o_exp),   64'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Alternate FP8/INT9 back to back on identical raw data.
        run_vec(2);
        run_vec(3);
        run_vec(2);

        // Drain the last beat before streaming.
        bus.i_ready = 1'b1;
        @(negedge clk);

        sent       = 0;
        rx         = 0;
        saw_block  = 1'b0;
        prev_stall = 1'b0;
        prev_mant  = '0;
        for (int c = 0; c < 40 && rx < 8; c++) begin
            if (c > 0) @(negedge clk);
            bus.i_ready    = !(c >= 3 && c <= 5);
            bus.i_valid    = (sent < 8);
            bus.i_datatype = MAC_DATATYPE_INT9;
            bus.i_data     = beat_data(sent);
            #1;
            if (bus.o_valid && bus.i_ready) begin
                chk($sformatf("stream_beat%0d", rx), 64'(bus.o_mant), 64'(beat_data(rx)));
                $display("stream cycle %0d beat %0d mant=%h", c, rx, bus.o_mant);
                rx++;
            end
            if (bus.o_valid && !bus.i_ready) begin
                if (prev_stall) chk("stall_stable", 64'(bus.o_mant), 64'(prev_mant));
                prev_mant  = bus.o_mant;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (!bus.o_ready) saw_block = 1'b1;
            if (bus.i_valid && bus.o_ready) sent++;
        end
        bus.i_valid = 1'b0;
        chk("stream_count", 64'(rx), 64'd8);
        chk("stream_backpressure", 64'(saw_block), 64'd1);

        // Two beats in flight, then async reset between clock edges.
        @(negedge clk);
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = beat_data(20);
        @(negedge clk);
        bus.i_data  = beat_data(21);
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("inflight_valid", 64'(bus.o_valid), 64'd1);
        chk("inflight_ready", 64'(bus.o_ready), 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.o_valid), 64'd0);
        chk("async_rst_ready", 64'(bus.o_ready), 64'd1);
        chk("async_rst_mant",  64'(bus.o_mant),  64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b1;
        #1;
        chk("post_rst_empty", 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        run_vec(0);
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_no_dup", 64'(bus.o_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
